mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide unit that sits directly downstream of the execute stage.
- Consumes the forwarded ALU operands and the M-extension opcode from execute.
- Produces the M-extension result for the EXE->LSU data path.
- Stalls the pipeline through stall_o while an operation is in flight. Multiply completes in 2 cycles; divide/remainder completes in 34 cycles (2 cycles for special cases).

---
 rtl/mul_div_unit.sv | 189 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: single-step multiply and radix-2 restoring
// divide on magnitudes, with divide-by-zero and signed-overflow results short-circuited.
module mul_div_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_i,
  input  logic [3:0]      alu_m_ops_i,
  input  logic [XLEN-1:0] operand_1_i,
  input  logic [XLEN-1:0] operand_2_i,
  input  logic            kill_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [3:0] OP_MUL    = 4'd1;
  localparam logic [3:0] OP_MULH   = 4'd2;
  localparam logic [3:0] OP_MULHSU = 4'd3;
  localparam logic [3:0] OP_MULHU  = 4'd4;
  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_DIVU   = 4'd6;
  localparam logic [3:0] OP_REM    = 4'd7;
  localparam logic [3:0] OP_REMU   = 4'd8;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SPEC, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [XLEN:0]          a_q, a_d;
  logic [XLEN:0]          b_q, b_d;
  logic [XLEN-1:0]        quot_q, quot_d;
  logic [XLEN-1:0]        rem_q, rem_d;
  logic                   neg_quot_q, neg_quot_d;
  logic                   neg_rem_q, neg_rem_d;
  logic [DIV_CNT_W-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]        result_q, result_d;
  logic                   done_q, done_d;

  logic                   legal_op;
  logic                   accept;
  logic                   is_mul_in;
  logic                   signed_div_in;
  logic                   op1_neg, op2_neg;
  logic                   div_zero_in, div_ovf_in;
  logic [XLEN-1:0]        spec_res;
  logic                   a_sgn_in, b_sgn_in;
  logic signed [2*XLEN-1:0] prod;
  logic [XLEN-1:0]        mul_res;
  logic [XLEN:0]          rem_shift, rem_diff;
  logic [XLEN-1:0]        quot_fix, rem_fix;

  assign legal_op = (alu_m_ops_i != 4'd0) && (alu_m_ops_i <= OP_REMU);
  assign accept   = (state_q == S_IDLE) && req_i && legal_op && !kill_i;
  assign stall_o  = req_i & legal_op & ~done_q & ~kill_i;
  assign done_o   = done_q;
  assign result_o = result_q;

  assign is_mul_in     = alu_m_ops_i <= OP_MULHU;
  assign signed_div_in = (alu_m_ops_i == OP_DIV) || (alu_m_ops_i == OP_REM);
  assign op1_neg       = signed_div_in & operand_1_i[XLEN-1];
  assign op2_neg       = signed_div_in & operand_2_i[XLEN-1];
  assign div_zero_in   = operand_2_i == '0;
  assign div_ovf_in    = signed_div_in && (operand_1_i == INT_MIN) && (operand_2_i == '1);
  assign a_sgn_in      = (alu_m_ops_i == OP_MULH) || (alu_m_ops_i == OP_MULHSU);
  assign b_sgn_in      = alu_m_ops_i == OP_MULH;

  always_comb begin
    if (div_zero_in) begin
      spec_res = ((alu_m_ops_i == OP_DIV) || (alu_m_ops_i == OP_DIVU)) ? '1 : operand_1_i;
    end else begin
      spec_res = (alu_m_ops_i == OP_DIV) ? INT_MIN : '0;
    end
  end

  // Operands are held as (XLEN+1)-bit values already sign- or zero-extended at accept,
  // so one signed product covers all four multiply flavours.
  assign prod    = (2*XLEN)'($signed(a_q)) * (2*XLEN)'($signed(b_q));
  assign mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign rem_diff  = rem_shift - b_q;
  assign quot_fix  = neg_quot_q ? -quot_q : quot_q;
  assign rem_fix   = neg_rem_q  ? -rem_q  : rem_q;

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves it unassigned;
    // otherwise this block would infer latches.
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = alu_m_ops_i;
          cnt_d = '0;
          if (is_mul_in) begin
            a_d     = {a_sgn_in & operand_1_i[XLEN-1], operand_1_i};
            b_d     = {b_sgn_in & operand_2_i[XLEN-1], operand_2_i};
            state_d = S_MUL;
          end else if (div_zero_in || div_ovf_in) begin
            quot_d  = spec_res;
            state_d = S_SPEC;
          end else begin
            quot_d     = op1_neg ? -operand_1_i : operand_1_i;
            b_d        = {1'b0, (op2_neg ? -operand_2_i : operand_2_i)};
            rem_d      = '0;
            neg_quot_d = op1_neg ^ op2_neg;
            neg_rem_d  = op1_neg;
            state_d    = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = mul_res;
        state_d  = S_DONE;
      end
      S_DIV: begin
        // After XLEN quotient bits have been retired, one more cycle applies the sign fix-up.
        if (cnt_q == DIV_CNT_W'(XLEN)) begin
          result_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quot_fix : rem_fix;
          state_d  = S_DONE;
        end else begin
          rem_d  = rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], ~rem_diff[XLEN]};
          cnt_d  = cnt_q + DIV_CNT_W'(1);
        end
      end
      S_SPEC: begin
        result_d = quot_q;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (kill_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign done_d = state_d == S_DONE;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // its *_d value from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, so nothing from an abandoned
    // operation is observable after reset.
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver pushes reference results, a negedge
// monitor pops and compares whenever done_o pulses.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [3:0]  alu_m_ops_i;
  logic [31:0] operand_1_i;
  logic [31:0] operand_2_i;
  logic        kill_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  mul_div_unit #(.XLEN(32), .DIV_CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .alu_m_ops_i (alu_m_ops_i),
    .operand_1_i (operand_1_i),
    .operand_2_i (operand_2_i),
    .kill_i      (kill_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .result_o    (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the RV32M definitions using 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int          sa, sb;
    longint      sa64, sb64, ua64, ub64;
    logic [63:0] p;
    logic        ovf;
    sa   = int'(a);
    sb   = int'(b);
    sa64 = longint'(sa);
    sb64 = longint'(sb);
    ua64 = longint'({32'b0, a});
    ub64 = longint'({32'b0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'd1: begin p = 64'(sa64 * sb64); return p[31:0]; end
      4'd2: begin p = 64'(sa64 * sb64); return p[63:32]; end
      4'd3: begin p = 64'(sa64 * ub64); return p[63:32]; end
      4'd4: begin p = 64'(ua64 * ub64); return p[63:32]; end
      4'd5: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      4'd6: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd7: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      4'd8: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done_o) begin
      check("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("result", result_o, exp_q.pop_front());
    end
  end

  // b2b: previous op kept req_i high through its done cycle. hold: keep req_i high after done.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit b2b, input bit hold);
    int  t0, acc_ofs, exp_lat, stall_bad;
    bit  seen, long_div;
    acc_ofs  = b2b ? 2 : 1;
    long_div = (op >= 4'd5) && (b != 0) &&
               !(((op == 4'd5) || (op == 4'd7)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
    exp_lat  = (long_div ? 33 : 1) + acc_ofs;
    alu_m_ops_i = op;
    operand_1_i = a;
    operand_2_i = b;
    req_i       = 1'b1;
    last_res    = ref_model(op, a, b);
    exp_q.push_back(last_res);
    t0        = cyc;
    stall_bad = 0;
    seen      = 1'b0;
    #1;
    if (stall_o !== ~done_o) stall_bad++;
    for (int n = 0; n < 80 && !seen; n++) begin
      @(negedge clk);
      if (stall_o !== ~done_o) stall_bad++;
      if (done_o) seen = 1'b1;
      else if (cyc - t0 >= acc_ofs) begin
        operand_1_i = $urandom;
        operand_2_i = $urandom;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc - t0), 32'(exp_lat));
    check("stall_while_busy", 32'(stall_bad), 32'd0);
    if (!hold) begin
      req_i = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int  bad;
    bit  prev_hold, hold;
    logic [3:0] rop;

    rst = 1'b1; req_i = 1'b0; kill_i = 1'b0;
    alu_m_ops_i = '0; operand_1_i = '0; operand_2_i = '0;
    repeat (3) @(negedge clk);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'h0);
    check("reset_stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'd1, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(4'd2, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(4'd4, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(4'd3, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    do_op(4'd5, 32'hFFFF_FFEC, 32'd6, 1'b0, 1'b0);
    do_op(4'd7, 32'hFFFF_FFEC, 32'd6, 1'b0, 1'b0);
    do_op(4'd6, 32'hFFFF_FFEC, 32'd6, 1'b0, 1'b0);
    do_op(4'd6, 32'd5, 32'd0, 1'b0, 1'b0);
    do_op(4'd7, 32'd5, 32'd0, 1'b0, 1'b0);
    do_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Kill a long divide mid-flight, then start a multiply straight away.
    alu_m_ops_i = 4'd5; operand_1_i = $urandom; operand_2_i = 32'd7; req_i = 1'b1;
    repeat (10) @(negedge clk);
    kill_i = 1'b1;
    #1 check("kill_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    kill_i = 1'b0; req_i = 1'b0;
    check("kill_no_done", 32'(done_o), 32'd0);
    check("kill_result_hold", result_o, last_res);
    do_op(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (done_o) bad++; end
    check("kill_no_late_done", 32'(bad), 32'd0);

    // Reset in the middle of a divide.
    alu_m_ops_i = 4'd6; operand_1_i = $urandom; operand_2_i = 32'd3; req_i = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; req_i = 1'b0;
    @(negedge clk);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_result", result_o, 32'h0);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (done_o) bad++; end
    check("midrst_no_done", 32'(bad), 32'd0);
    check("midrst_result_kept", result_o, 32'h0);

    // NONE and an illegal opcode are never accepted.
    foreach (exp_q[i]) ;
    for (int k = 0; k < 2; k++) begin
      alu_m_ops_i = (k == 0) ? 4'd0 : 4'd12;
      operand_1_i = $urandom; operand_2_i = $urandom; req_i = 1'b1;
      bad = 0;
      #1 if (stall_o) bad++;
      repeat (6) begin @(negedge clk); if (stall_o || done_o) bad++; end
      check((k == 0) ? "op_none_ignored" : "op_illegal_ignored", 32'(bad), 32'd0);
      req_i = 1'b0;
      @(negedge clk);
    end

    // Back-to-back with req_i held across the first done.
    do_op(4'd1, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 1'b1);
    do_op(4'd6, 32'hFFFF_FFFF, 32'd10, 1'b1, 1'b0);

    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rop  = 4'($urandom_range(1, 8));
      hold = 1'($urandom_range(0, 1));
      do_op(rop, pick_operand(), pick_operand(), prev_hold, hold);
      prev_hold = hold;
    end
    if (prev_hold) begin
      req_i = 1'b0;
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
